if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS32 core. Holds the PC and issues fetch requests to instruction memory over a ready handshake. Applies the ID-stage branch decision (`PCSrc_ID`, produced by the ID-stage branch AND) as a PC redirect. Presents `Instr_ID`/`PC_plus4_ID` to decode, honouring the hazard-unit stall.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PCSrc_ID`  in  1  taken branch/jump from ID; single-cycle qualifier.
- `Branch_target_ID`  in  32  redirect address; valid when `PCSrc_ID`=1.
- `Stall_IF`  in  1  hazard stall; hold PC and IF/ID.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, equal to the PC register.
- `imem_ready`  in  1  `imem_rdata` valid this cycle; handshake completes when `imem_req`&`imem_ready`.
- `imem_rdata`  in  32  fetched instruction.
- `Instr_ID`  out  32  IF/ID instruction; 0 (NOP) when bubble.
- `PC_plus4_ID`  out  32  IF/ID PC+4 of `Instr_ID`.
- `Valid_ID`  out  1  IF/ID holds a real instruction.

## Operation
- Reset (async, `rst_n`=0): PC=`RESET_PC`; `Instr_ID`=0, `PC_plus4_ID`=0, `Valid_ID`=0; state FETCH; skid buffer empty; pending-branch cleared. `imem_req`=0 while `rst_n`=0.
- FSM states FETCH and HOLD.
- FETCH: `imem_req`=1.
  - Accept (`imem_ready`=1) with `Stall_IF`=0: IF/ID <= {PC+4, `imem_rdata`, valid=1}; PC <= next PC.
  - Accept with `Stall_IF`=1: IF/ID held; `imem_rdata` and PC+4 latched into skid buffer; PC <= next PC; go to HOLD.
  - No accept, `Stall_IF`=0: IF/ID <= bubble (0, 0, valid=0); PC held.
  - No accept, `Stall_IF`=1: everything held.
- HOLD: `imem_req`=0; IF/ID held while `Stall_IF`=1. On `Stall_IF`=0: IF/ID <= skid buffer (valid=1); return to FETCH.
- Next PC = PC+4, unless a redirect applies (see Configuration). Arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- `PCSrc_ID` sampled while `Stall_IF`=1 is ignored; ID re-presents the branch after the stall.
- Bits [1:0] of `Branch_target_ID` pass through unchanged; no alignment check.

## Timing
- `imem_addr` is registered PC; `imem_rdata` sampled in the same cycle as `imem_ready`. Zero-wait memory sustains 1 instruction/cycle.
- Fetch-to-decode latency: `Instr_ID` valid the cycle after accept.
- Redirect: `imem_addr`=target on the cycle after the redirect edge.
- Reset deasserted mid-wait: first request is to `RESET_PC` on the first cycle with `rst_n`=1.

## Configuration
- `IF_BRANCH_FLUSH_EN` defined (no delay slot):
  - `PCSrc_ID`=1 & `Stall_IF`=0: PC <= `Branch_target_ID` regardless of `imem_ready`; IF/ID <= bubble; skid buffer discarded; state FETCH.
  - Any in-flight fetch result that cycle is dropped.
- Undefined (MIPS delay slot):
  - Redirect takes effect on the accept of the delay-slot fetch. That instruction enters IF/ID normally, then PC <= target.
  - `PCSrc_ID` without accept sets a pending-branch register holding the target; the next accept uses it and clears it.
  - A new `PCSrc_ID` while a branch is pending overwrites the pending target.

## Test plan
- Reset with `RESET_PC`=32'hBFC0_0000, zero-wait memory: `imem_addr` sequence BFC00000, BFC00004, BFC00008; `Valid_ID`=1 from cycle 2; `PC_plus4_ID`=BFC00004 first.
- `imem_ready` low 3 cycles at PC=0x10: `Valid_ID`=0, `Instr_ID`=0 for 3 cycles; `imem_addr` stays 0x10; then instruction at 0x10 enters with `PC_plus4_ID`=0x14.
- `Stall_IF`=1 for 2 cycles during an accept at 0x20: IF/ID unchanged; `imem_req`=0 in HOLD. After release, `Instr_ID`=mem[0x20]; next `imem_addr`=0x24.
- Flush config, `PCSrc_ID`=1, target 0x100, while fetching 0x24: next `imem_addr`=0x100; `Valid_ID`=0 for one cycle; no instruction from 0x24.
- No-flush config, same stimulus with `imem_ready`=0 that cycle and 1 the next: mem[0x24] enters IF/ID (`PC_plus4_ID`=0x28); the following `imem_addr`=0x100.
- `rst_n` asserted while in HOLD with pending branch: immediately `Valid_ID`=0 and `imem_req`=0; after release, `imem_addr`=`RESET_PC`; pending target never used.

Source files
------------

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS32
// core. It holds the PC, fetches from instruction memory over a req/ready
// handshake, and applies the branch decision from ID as a PC redirect. The
// fetched instruction and its PC+4 are presented to decode. The hazard-unit
// stall is honoured.
//
// Parameters:
//   RESET_PC          PC value loaded at reset.
//
// Ports:
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   PCSrc_ID          taken branch/jump from ID (single-cycle qualifier)
//   Branch_target_ID  redirect address, valid with PCSrc_ID
//   Stall_IF          hazard stall: hold PC and IF/ID
//   imem_req          fetch request (low in HOLD and while in reset)
//   imem_addr         fetch address (the PC register)
//   imem_ready        imem_rdata valid; handshake = imem_req & imem_ready
//   imem_rdata        fetched instruction
//   Instr_ID          IF/ID instruction (0 = NOP when bubble)
//   PC_plus4_ID       IF/ID PC+4 of Instr_ID
//   Valid_ID          IF/ID holds a real instruction
//
// Configuration macro:
//   IF_BRANCH_FLUSH_EN  defined: no delay slot. A taken branch redirects the
//                       PC at once, drops any fetch result from that cycle,
//                       and flushes IF/ID and the skid buffer.
//                       undefined: MIPS delay slot. The redirect is applied
//                       on the accept of the delay-slot fetch. If that fetch
//                       has not completed yet, the target is parked in a
//                       pending-branch register.
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCSrc_ID,
    input  logic [31:0] Branch_target_ID,
    input  logic        Stall_IF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr_ID,
    output logic [31:0] PC_plus4_ID,
    output logic        Valid_ID
);

    typedef enum logic {
        StFetch = 1'b0,
        StHold  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    // Skid buffer: an instruction accepted while decode was stalled. Its
    // occupancy is implied by StHold.
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        accept;
    logic        redirect;

`ifndef IF_BRANCH_FLUSH_EN
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
`endif

    // ------------------------------------------------------------------
    // Handshake and redirect qualification
    // ------------------------------------------------------------------
    assign pc_plus4  = pc_q + 32'd4;   // modulo 2^32, wraps to 0
    assign imem_addr = pc_q;
    // Gate with rst_n so that no request is issued while reset is held.
    assign imem_req  = rst_n && (state_q == StFetch);
    assign accept    = imem_req && imem_ready;
    // A branch seen during a stall is ignored; ID re-presents it later.
    assign redirect  = PCSrc_ID && !Stall_IF;

`ifdef IF_BRANCH_FLUSH_EN
    assign next_pc = pc_plus4;
`else
    // A fresh branch takes priority over an older pending one.
    always_comb begin
        next_pc = pc_plus4;
        if (redirect) begin
            next_pc = Branch_target_ID;
        end else if (pend_valid_q) begin
            next_pc = pend_target_q;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
`ifndef IF_BRANCH_FLUSH_EN
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
`endif

        unique case (state_q)
            StFetch: begin
                if (accept) begin
                    pc_d = next_pc;
                    if (!Stall_IF) begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                    end else begin
                        // Decode is busy: park the result and stop fetching.
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = pc_plus4;
                        state_d      = StHold;
                    end
                end else if (!Stall_IF) begin
                    instr_d = 32'h0;
                    pc4_d   = 32'h0;
                    valid_d = 1'b0;
                end
            end
            StHold: begin
                if (!Stall_IF) begin
                    instr_d = skid_instr_q;
                    pc4_d   = skid_pc4_q;
                    valid_d = 1'b1;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase

`ifdef IF_BRANCH_FLUSH_EN
        // A taken branch overrides everything decided above: the result of
        // any fetch completing this cycle is wrong-path and is discarded.
        if (redirect) begin
            pc_d    = Branch_target_ID;
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
            state_d = StFetch;
        end
`else
        // The accept that completes the delay slot consumes the branch.
        // Without an accept the target waits. A newer branch overwrites it.
        if (accept) begin
            pend_valid_d = 1'b0;
        end else if (redirect) begin
            pend_valid_d  = 1'b1;
            pend_target_d = Branch_target_ID;
        end
`endif
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            instr_q      <= 32'h0;
            pc4_q        <= 32'h0;
            valid_q      <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

`ifndef IF_BRANCH_FLUSH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end
`endif

    assign Instr_ID    = instr_q;
    assign PC_plus4_ID = pc4_q;
    assign Valid_ID    = valid_q;

endmodule
